// File: rtl/psum_accumulator.sv
// Accumulates POX-lane signed partial products over len beats per group and
// emits each group's 16-bit saturated sum as a one-cycle pulse, with no bubble between groups.
module psum_accumulator #(
  parameter int unsigned POX   = 3,
  parameter int unsigned DW    = 16,
  parameter int unsigned CNT_W = 12,
  parameter int unsigned ACC_W = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    cfg_len,
  input  logic [CNT_W-1:0]    cfg_groups,
  input  logic [POX*DW-1:0]   in_data,
  input  logic                in_valid,
  output logic [POX*DW-1:0]   acc_out,
  output logic                acc_out_valid,
  output logic                busy,
  output logic                done,
  output logic [POX-1:0]      sat_flag
);

  localparam int unsigned EXT_W = ACC_W - DW;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(EXT_W + 1){1'b0}}, {(DW - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(EXT_W + 1){1'b1}}, {(DW - 1){1'b0}}};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACC  = 1'b1
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_len;
  logic [CNT_W-1:0]         r_groups;
  logic [CNT_W-1:0]         r_beat_cnt;
  logic [CNT_W-1:0]         r_grp_cnt;
  logic                     r_first;
  logic signed [ACC_W-1:0]  r_acc [POX];
  logic [POX*DW-1:0]        r_acc_out;
  logic                     r_acc_out_valid;
  logic                     r_busy;
  logic                     r_done;
  logic [POX-1:0]           r_sat_flag;

  logic signed [ACC_W-1:0]  w_sum [POX];
  logic [POX*DW-1:0]        w_sat_data;
  logic [POX-1:0]           w_clip;
  logic                     w_last_beat;
  logic                     w_last_grp;

  // Per-lane sum of the current beat, restarting from zero on a group's first beat.
  always_comb begin
    w_sat_data = '0;
    w_clip     = '0;
    for (int i = 0; i < POX; i++) begin
      w_sum[i] = (r_first ? ACC_W'(0) : r_acc[i])
               + $signed({{EXT_W{in_data[i*DW + DW - 1]}}, in_data[i*DW +: DW]});
      if (w_sum[i] > SAT_MAX) begin
        w_sat_data[i*DW +: DW] = SAT_MAX[DW-1:0];
        w_clip[i]              = 1'b1;
      end else if (w_sum[i] < SAT_MIN) begin
        w_sat_data[i*DW +: DW] = SAT_MIN[DW-1:0];
        w_clip[i]              = 1'b1;
      end else begin
        w_sat_data[i*DW +: DW] = w_sum[i][DW-1:0];
      end
    end
  end

  assign w_last_beat = in_valid && (r_beat_cnt == (r_len - CNT_W'(1)));
  assign w_last_grp  = (r_grp_cnt == (r_groups - CNT_W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_len           <= '0;
      r_groups        <= '0;
      r_beat_cnt      <= '0;
      r_grp_cnt       <= '0;
      r_first         <= 1'b0;
      for (int i = 0; i < POX; i++) r_acc[i] <= '0;
      r_acc_out       <= '0;
      r_acc_out_valid <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_sat_flag      <= '0;
    end else begin
      r_acc_out_valid <= 1'b0;
      r_done          <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len      <= (cfg_len    == '0) ? CNT_W'(1) : cfg_len;
            r_groups   <= (cfg_groups == '0) ? CNT_W'(1) : cfg_groups;
            r_beat_cnt <= '0;
            r_grp_cnt  <= '0;
            r_first    <= 1'b1;
            r_sat_flag <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_ACC;
          end
        end
        S_ACC: begin
          if (in_valid) begin
            for (int i = 0; i < POX; i++) r_acc[i] <= w_sum[i];
            r_first    <= 1'b0;
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (w_last_beat) begin
              r_acc_out       <= w_sat_data;
              r_acc_out_valid <= 1'b1;
              r_sat_flag      <= r_sat_flag | w_clip;
              r_beat_cnt      <= '0;
              r_first         <= 1'b1;
              r_grp_cnt       <= r_grp_cnt + CNT_W'(1);
              if (w_last_grp) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign acc_out       = r_acc_out;
  assign acc_out_valid = r_acc_out_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign sat_flag      = r_sat_flag;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed self-checking bench for psum_accumulator: one task per scenario,
// hand-computed expected values, outputs sampled 1 time unit after the rising edge.
module tb_psum_accumulator;

  localparam int unsigned POX   = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 12;
  localparam int unsigned ACC_W = 28;

  logic                clk;
  logic                rst;
  logic                start;
  logic [CNT_W-1:0]    cfg_len;
  logic [CNT_W-1:0]    cfg_groups;
  logic [POX*DW-1:0]   in_data;
  logic                in_valid;
  logic [POX*DW-1:0]   acc_out;
  logic                acc_out_valid;
  logic                busy;
  logic                done;
  logic [POX-1:0]      sat_flag;

  int n_pass;
  int n_total;

  psum_accumulator #(.POX(POX), .DW(DW), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_len       (cfg_len),
    .cfg_groups    (cfg_groups),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .acc_out       (acc_out),
    .acc_out_valid (acc_out_valid),
    .busy          (busy),
    .done          (done),
    .sat_flag      (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [POX*DW-1:0] pk(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input int a, input int b, input int c);
    in_valid = v;
    in_data  = pk(a, b, c);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start(input int len, input int groups);
    start      = 1'b1;
    cfg_len    = CNT_W'(len);
    cfg_groups = CNT_W'(groups);
    tick();
    start      = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [POX*DW-1:0] d, input logic dn);
    n_total++;
    if (acc_out_valid !== v || acc_out !== d || done !== dn)
      $display("FAIL %s: got valid=%b data=%h done=%b, want valid=%b data=%h done=%b",
               name, acc_out_valid, acc_out, done, v, d, dn);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_total++;
    if (acc_out !== '0 || acc_out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sat_flag !== '0)
      $display("FAIL reset: got data=%h valid=%b busy=%b done=%b sat=%b, want all zero",
               acc_out, acc_out_valid, busy, done, sat_flag);
    else n_pass++;
    tick();
    tick();
    rst = 1'b0;
    tick();
    // in_valid while idle must not produce output
    beat(1'b1, 9, 9, 9);
    chk_out("idle_ignores_valid", 1'b0, '0, 1'b0);
  endtask

  task automatic test_len1();
    do_start(1, 3);
    n_total++;
    if (busy !== 1'b1) $display("FAIL len1_busy: got %b want 1", busy);
    else n_pass++;
    beat(1'b1, 5, -7, 100);
    chk_out("len1_g0", 1'b1, pk(5, -7, 100), 1'b0);
    beat(1'b1, 1, 2, 3);
    chk_out("len1_g1", 1'b1, pk(1, 2, 3), 1'b0);
    beat(1'b1, 0, 0, -1);
    chk_out("len1_g2", 1'b1, pk(0, 0, -1), 1'b1);
    n_total++;
    if (busy !== 1'b0 || sat_flag !== 3'b000)
      $display("FAIL len1_end: got busy=%b sat=%b want busy=0 sat=000", busy, sat_flag);
    else n_pass++;
    tick();
    chk_out("len1_hold", 1'b0, pk(0, 0, -1), 1'b0);
  endtask

  task automatic test_back_to_back();
    do_start(4, 2);
    beat(1'b1, 10, 0, 0);
    beat(1'b1, 20, 0, 0);
    beat(1'b1, 30, 0, 0);
    chk_out("b2b_early", 1'b0, pk(0, 0, -1), 1'b0);
    beat(1'b1, 40, 0, 0);
    chk_out("b2b_g0", 1'b1, pk(100, 0, 0), 1'b0);
    beat(1'b1, 1, 0, 0);
    chk_out("b2b_hold", 1'b0, pk(100, 0, 0), 1'b0);
    beat(1'b1, 1, 0, 0);
    beat(1'b1, 1, 0, 0);
    beat(1'b1, 1, 0, 0);
    chk_out("b2b_g1", 1'b1, pk(4, 0, 0), 1'b1);
  endtask

  task automatic test_saturation();
    do_start(3, 1);
    for (int k = 0; k < 3; k++) beat(1'b1, 5, 20000, -20000);
    chk_out("sat_clip", 1'b1, pk(15, 32767, -32768), 1'b1);
    n_total++;
    if (sat_flag !== 3'b110) $display("FAIL sat_flag: got %b want 110", sat_flag);
    else n_pass++;
    do_start(2, 1);
    n_total++;
    if (sat_flag !== 3'b000) $display("FAIL sat_clear: got %b want 000", sat_flag);
    else n_pass++;
    // exact limits do not clip; 32768 does
    beat(1'b1, 32767, -32768, 16384);
    beat(1'b1, 0, 0, 16384);
    chk_out("sat_edge", 1'b1, pk(32767, -32768, 32767), 1'b1);
    n_total++;
    if (sat_flag !== 3'b100) $display("FAIL sat_edge_flag: got %b want 100", sat_flag);
    else n_pass++;
  endtask

  task automatic test_gapped();
    logic pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   bad;
    do_start(4, 1);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      beat(pat[k], pat[k] ? 2 : 99, 0, 0);
      if (acc_out_valid !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL gap_early: got %0d early pulses want 0", bad);
    else n_pass++;
    beat(pat[6], 2, 0, 0);
    chk_out("gap_sum", 1'b1, pk(8, 0, 0), 1'b1);
  endtask

  task automatic test_control();
    do_start(0, 0);
    beat(1'b1, 7, 8, 9);
    chk_out("zero_cfg", 1'b1, pk(7, 8, 9), 1'b1);
    do_start(2, 1);
    beat(1'b1, 3, 0, 0);
    // start during ACC with a different config must be ignored
    start = 1'b1;
    cfg_len = CNT_W'(1);
    tick();
    start = 1'b0;
    chk_out("start_in_acc", 1'b0, pk(7, 8, 9), 1'b0);
    beat(1'b1, 4, 0, 0);
    chk_out("start_ignored", 1'b1, pk(7, 0, 0), 1'b1);
    do_start(1, 1);
    n_total++;
    if (busy !== 1'b1) $display("FAIL start_on_done: got busy=%b want 1", busy);
    else n_pass++;
    beat(1'b1, 11, 0, 0);
    chk_out("start_on_done_out", 1'b1, pk(11, 0, 0), 1'b1);
  endtask

  task automatic test_reset_mid();
    do_start(4, 1);
    beat(1'b1, 50, 50, 50);
    beat(1'b1, 50, 50, 50);
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if (acc_out !== '0 || acc_out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sat_flag !== '0)
      $display("FAIL reset_mid: got data=%h valid=%b busy=%b done=%b sat=%b, want all zero",
               acc_out, acc_out_valid, busy, done, sat_flag);
    else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    do_start(2, 1);
    beat(1'b1, 1, 1, 1);
    beat(1'b1, 2, 2, 2);
    chk_out("post_reset_sum", 1'b1, pk(3, 3, 3), 1'b1);
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst        = 1'b1;
    start      = 1'b0;
    cfg_len    = '0;
    cfg_groups = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    test_reset();
    test_len1();
    test_back_to_back();
    test_saturation();
    test_gapped();
    test_control();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
